key_debounce_array: RTL and testbench

KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

---
 rtl/key_debounce_array.sv | 176 +++++++++++++++++
 tb/tb_key_debounce_array.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_array.sv
// key_debounce_array
//   Debounces KEY_NUM active-low push keys. Each key has its own two-flop
//   synchroniser and its own counter. A level change is accepted after it has
//   been stable for DEBOUNCE_CYC cycles. Accepted presses and releases give
//   one-cycle pulses, and the lowest pressed key is encoded on key_code.
//
//   Optional feature (macro KEY_LONG_PRESS_EN): emits one key_long pulse per
//   press once key_state has been 1 for LONG_CYC cycles. The long-press count
//   reuses the debounce counter. Without the macro, key_long is tied to 0 and
//   the counter is only as wide as the debounce count needs.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous reset, active-low
//   key_in       in   [KEY_NUM] raw key levels, 0 = pressed, asynchronous
//   key_state    out  [KEY_NUM] debounced level, 1 = pressed
//   key_press    out  [KEY_NUM] one-cycle pulse on an accepted press
//   key_release  out  [KEY_NUM] one-cycle pulse on an accepted release
//   key_code     out  [4] 1-based index of the lowest pressed key, 0 = none
//   key_valid    out  one-cycle qualifier for key_code
//   key_long     out  [KEY_NUM] one-cycle long-press pulse
module key_debounce_array #(
  parameter int KEY_NUM      = 4,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int LONG_CYC     = 50_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [3:0]         key_code,
  output logic               key_valid,
  output logic [KEY_NUM-1:0] key_long
);

`ifdef KEY_LONG_PRESS_EN
  localparam int CNT_W = $clog2(LONG_CYC + 1);
`else
  localparam int CNT_W = $clog2(DEBOUNCE_CYC);
`endif
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  if (KEY_NUM < 1 || KEY_NUM > 15) begin : g_bad_key_num
    $error("key_debounce_array: KEY_NUM must be 1..15");
  end
  if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
    $error("key_debounce_array: DEBOUNCE_CYC must be at least 2");
  end
  if (LONG_CYC <= DEBOUNCE_CYC) begin : g_bad_long
    $error("key_debounce_array: LONG_CYC must exceed DEBOUNCE_CYC");
  end

  logic [KEY_NUM-1:0] sync1_q, sync2_q;
  logic [KEY_NUM-1:0] state_d, state_q;
  logic [KEY_NUM-1:0] state_last_q;
  logic [KEY_NUM-1:0] press_d, press_q;
  logic [KEY_NUM-1:0] release_d, release_q;
  logic [3:0]         code_d, code_q;
  logic               valid_d, valid_q;
  logic [KEY_NUM-1:0] long_d, long_q;
  logic [CNT_W-1:0]   cnt_d [KEY_NUM];
  logic [CNT_W-1:0]   cnt_q [KEY_NUM];
  logic [CNT_W-1:0]   eff;
  logic               lvl;

`ifdef KEY_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYC);
  // diff_q: the level differed from key_state last cycle, so cnt_q holds a
  // debounce count; otherwise (while pressed) it holds the long-press count.
  logic [KEY_NUM-1:0] diff_d, diff_q;
  logic [KEY_NUM-1:0] long_done_d, long_done_q;
`endif

  always_comb begin
    state_d   = state_q;
    release_d = '0;
    long_d    = '0;
    eff       = '0;
    lvl       = 1'b0;
`ifdef KEY_LONG_PRESS_EN
    diff_d      = '0;
    long_done_d = long_done_q;
`endif
    for (int i = 0; i < KEY_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      lvl      = ~sync2_q[i];
      if (lvl != state_q[i]) begin
`ifdef KEY_LONG_PRESS_EN
        diff_d[i] = 1'b1;
        // First differing cycle: discard any long-press count in cnt_q.
        eff = diff_q[i] ? cnt_q[i] : '0;
`else
        eff = cnt_q[i];
`endif
        if (eff == DEB_LAST) begin
          state_d[i] = lvl;
          cnt_d[i]   = '0;
`ifdef KEY_LONG_PRESS_EN
          long_done_d[i] = 1'b0;
`endif
        end else begin
          cnt_d[i] = eff + CNT_W'(1);
        end
      end else begin
`ifdef KEY_LONG_PRESS_EN
        if (state_q[i]) begin
          // A release bounce restarts the long-press count.
          eff = diff_q[i] ? '0 : cnt_q[i];
          if (eff == LONG_LAST && !long_done_q[i]) begin
            long_d[i]      = 1'b1;
            long_done_d[i] = 1'b1;
          end
          cnt_d[i] = (eff == LONG_MAX) ? eff : eff + CNT_W'(1);
        end else begin
          cnt_d[i] = '0;
        end
`else
        cnt_d[i] = '0;
`endif
      end
    end
    // Pulses come one cycle after the key_state change.
    press_d   = state_q & ~state_last_q;
    release_d = ~state_q & state_last_q;
    valid_d   = |press_d;
    code_d    = '0;
    for (int i = KEY_NUM - 1; i >= 0; i--) begin
      if (press_d[i]) code_d = 4'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      state_q      <= '0;
      state_last_q <= '0;
      press_q      <= '0;
      release_q    <= '0;
      code_q       <= '0;
      valid_q      <= 1'b0;
      long_q       <= '0;
      for (int i = 0; i < KEY_NUM; i++) cnt_q[i] <= '0;
`ifdef KEY_LONG_PRESS_EN
      diff_q      <= '0;
      long_done_q <= '0;
`endif
    end else begin
      sync1_q      <= key_in;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      state_last_q <= state_q;
      press_q      <= press_d;
      release_q    <= release_d;
      code_q       <= code_d;
      valid_q      <= valid_d;
      long_q       <= long_d;
      for (int i = 0; i < KEY_NUM; i++) cnt_q[i] <= cnt_d[i];
`ifdef KEY_LONG_PRESS_EN
      diff_q      <= diff_d;
      long_done_q <= long_done_d;
`endif
    end
  end

  assign key_state   = state_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_code    = code_q;
  assign key_valid   = valid_q;
  assign key_long    = long_q;

endmodule

// File: tb/tb_key_debounce_array.sv
// Directed bench for key_debounce_array with KEY_NUM=4, DEBOUNCE_CYC=8,
// LONG_CYC=32. Inputs change 1 time unit after a rising edge, so the next
// rising edge is edge 1. Outputs are sampled 1 time unit after each edge.
module tb_key_debounce_array;
  localparam int KN = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [KN-1:0] key_in = '1;
  logic [KN-1:0] key_state, key_press, key_release, key_long;
  logic [3:0]    key_code;
  logic          key_valid;

  int n_cmp = 0;
  int n_err = 0;

  key_debounce_array #(.KEY_NUM(KN), .DEBOUNCE_CYC(8), .LONG_CYC(32)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_state(key_state),
    .key_press(key_press), .key_release(key_release), .key_code(key_code),
    .key_valid(key_valid), .key_long(key_long)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    key_in = '1;
    repeat (3) tick();
    n_cmp++;
    if ({key_state, key_press, key_release, key_long} !== 16'h0) begin
      n_err++; $display("FAIL reset_vectors: got %h expected 0", {key_state, key_press, key_release, key_long});
    end
    n_cmp++;
    if ({key_code, key_valid} !== 5'h0) begin
      n_err++; $display("FAIL reset_code: got %h expected 0", {key_code, key_valid});
    end
    rst = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if ({key_state, key_press, key_valid} !== 9'h0) begin
      n_err++; $display("FAIL idle_after_reset: got %h expected 0", {key_state, key_press, key_valid});
    end
  endtask

  task automatic test_clean_press();
    int early;
    early = 0;
    key_in[2] = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e <= 10 && key_press !== 4'b0) early++;
      if (e == 9) begin
        n_cmp++;
        if (key_state !== 4'b0000) begin
          n_err++; $display("FAIL press_state_e9: got %b expected 0000", key_state);
        end
      end
      if (e == 10) begin
        n_cmp++;
        if (key_state !== 4'b0100) begin
          n_err++; $display("FAIL press_state_e10: got %b expected 0100", key_state);
        end
      end
      if (e == 11) begin
        n_cmp++;
        if ({key_press, key_code, key_valid} !== {4'b0100, 4'd3, 1'b1}) begin
          n_err++; $display("FAIL press_e11: got press=%b code=%0d valid=%b expected 0100/3/1", key_press, key_code, key_valid);
        end
      end
      if (e == 12) begin
        n_cmp++;
        if ({key_press, key_code, key_valid} !== 9'h0) begin
          n_err++; $display("FAIL press_e12: got press=%b code=%0d valid=%b expected 0/0/0", key_press, key_code, key_valid);
        end
      end
    end
    n_cmp++;
    if (early !== 0) begin
      n_err++; $display("FAIL press_early: got %0d early pulses expected 0", early);
    end
    key_in = '1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 10) begin
        n_cmp++;
        if (key_release !== 4'b0) begin
          n_err++; $display("FAIL release_e10: got %b expected 0000", key_release);
        end
      end
      if (e == 11) begin
        n_cmp++;
        if ({key_release, key_valid, key_code} !== {4'b0100, 1'b0, 4'd0}) begin
          n_err++; $display("FAIL release_e11: got rel=%b valid=%b code=%0d expected 0100/0/0", key_release, key_valid, key_code);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int bad;
    bad = 0;
    for (int p = 0; p < 5; p++) begin
      key_in[0] = 1'b0;
      for (int c = 0; c < 5; c++) begin
        tick();
        if (key_state[0] !== 1'b0 || key_press !== 4'b0) bad++;
      end
      key_in[0] = 1'b1;
      tick();
      if (key_state[0] !== 1'b0 || key_press !== 4'b0) bad++;
    end
    key_in[0] = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e <= 10 && key_press !== 4'b0) bad++;
      if (e == 11) begin
        n_cmp++;
        if ({key_press, key_code} !== {4'b0001, 4'd1}) begin
          n_err++; $display("FAIL bounce_press: got press=%b code=%0d expected 0001/1", key_press, key_code);
        end
      end
    end
    n_cmp++;
    if (bad !== 0) begin
      n_err++; $display("FAIL bounce_quiet: got %0d bad samples expected 0", bad);
    end
    key_in = '1;
    repeat (12) tick();
  endtask

  task automatic test_simultaneous();
    int vcnt;
    vcnt = 0;
    key_in = 4'b0101;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (key_valid === 1'b1) vcnt++;
      if (e == 11) begin
        n_cmp++;
        if ({key_press, key_code, key_valid} !== {4'b1010, 4'd2, 1'b1}) begin
          n_err++; $display("FAIL simul_press: got press=%b code=%0d valid=%b expected 1010/2/1", key_press, key_code, key_valid);
        end
      end
    end
    n_cmp++;
    if (vcnt !== 1) begin
      n_err++; $display("FAIL simul_valid_count: got %0d expected 1", vcnt);
    end
    key_in = '1;
    repeat (12) tick();
  endtask

  task automatic test_independence();
    key_in[0] = 1'b0;
    for (int e = 1; e <= 11; e++) begin
      tick();
      if (e <= 12) key_in[1] = ~key_in[1];
      if (e == 10) begin
        n_cmp++;
        if (key_press !== 4'b0000) begin
          n_err++; $display("FAIL indep_e10: got %b expected 0000", key_press);
        end
      end
      if (e == 11) begin
        n_cmp++;
        if ({key_press, key_state} !== {4'b0001, 4'b0001}) begin
          n_err++; $display("FAIL indep_e11: got press=%b state=%b expected 0001/0001", key_press, key_state);
        end
      end
    end
    key_in = '1;
    repeat (14) tick();
  endtask

  task automatic test_release_long();
    int lcnt;
    int ledge;
    int exp_cnt;
    int exp_edge;
    int early_rel;
`ifdef KEY_LONG_PRESS_EN
    exp_cnt = 1;
    exp_edge = 42;
`else
    exp_cnt = 0;
    exp_edge = -1;
`endif
    lcnt = 0;
    ledge = -1;
    early_rel = 0;
    key_in[0] = 1'b0;
    for (int e = 1; e <= 90; e++) begin
      tick();
      if (key_long !== 4'b0) begin
        lcnt++;
        if (ledge < 0) ledge = e;
        if (key_long !== 4'b0001) lcnt += 100;
      end
      if (e == 11) begin
        n_cmp++;
        if (key_press !== 4'b0001) begin
          n_err++; $display("FAIL hold_press: got %b expected 0001", key_press);
        end
      end
    end
    n_cmp++;
    if (lcnt !== exp_cnt) begin
      n_err++; $display("FAIL long_count: got %0d expected %0d", lcnt, exp_cnt);
    end
    n_cmp++;
    if (ledge !== exp_edge) begin
      n_err++; $display("FAIL long_edge: got %0d expected %0d", ledge, exp_edge);
    end
    key_in[0] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e <= 10 && key_release !== 4'b0) early_rel++;
      if (key_long !== 4'b0) lcnt++;
      if (e == 11) begin
        n_cmp++;
        if ({key_release, key_valid, key_state} !== {4'b0001, 1'b0, 4'b0000}) begin
          n_err++; $display("FAIL long_release: got rel=%b valid=%b state=%b expected 0001/0/0000", key_release, key_valid, key_state);
        end
      end
    end
    n_cmp++;
    if (early_rel !== 0 || lcnt !== exp_cnt) begin
      n_err++; $display("FAIL release_quiet: got early=%0d long=%0d expected 0/%0d", early_rel, lcnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    pulses = 0;
    key_in[2] = 1'b0;
    repeat (7) tick();
    rst = 1'b0;
    #2;
    n_cmp++;
    if ({key_state, key_press, key_release, key_long, key_code, key_valid} !== 21'h0) begin
      n_err++; $display("FAIL mid_reset_outputs: got %h expected 0", {key_state, key_press, key_release, key_long, key_code, key_valid});
    end
    repeat (4) begin
      tick();
      if ({key_state, key_press, key_release, key_long, key_valid} !== 17'h0) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_err++; $display("FAIL mid_reset_quiet: got %0d active samples expected 0", pulses);
    end
    rst = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 10) begin
        n_cmp++;
        if ({key_state, key_press} !== {4'b0100, 4'b0000}) begin
          n_err++; $display("FAIL after_reset_e10: got state=%b press=%b expected 0100/0000", key_state, key_press);
        end
      end
      if (e == 11) begin
        n_cmp++;
        if ({key_press, key_code, key_valid} !== {4'b0100, 4'd3, 1'b1}) begin
          n_err++; $display("FAIL after_reset_e11: got press=%b code=%0d valid=%b expected 0100/3/1", key_press, key_code, key_valid);
        end
      end
    end
    key_in = '1;
    repeat (12) tick();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_independence();
    test_release_long();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
